blackjack_round_ctrl: RTL and testbench

Round sequencer for the blackjack game. It requests cards from the card-draw source through a req/valid handshake and deals two cards each to player and dealer. It then runs the player hit/stand turn and the dealer auto-draw turn, and reports the outcome. It sits between the pushbutton/switch inputs and the card-draw block, and drives the sum/result displays.

---
 rtl/blackjack_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deals two cards each, runs the player hit/stand turn
// and the dealer auto-draw turn through a card req/valid handshake, then reports the outcome.
module blackjack_round_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21,
  parameter int SUM_W        = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hit,
  input  logic             stand,
  input  logic             card_valid,
  input  logic [3:0]       card_value,
  output logic             card_req,
  output logic [SUM_W-1:0] player_sum,
  output logic [SUM_W-1:0] dealer_sum,
  output logic [1:0]       result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE,
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    PLAYER_TURN,
    PLAYER_DRAW,
    DEALER_TURN,
    DEALER_DRAW,
    RESULT
  } state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [SUM_W-1:0] BUST_SUM  = SUM_W'(BUST_LIMIT);
  localparam logic [SUM_W-1:0] STAND_SUM = SUM_W'(DEALER_STAND);

  state_t           state;
  state_t           next_state;
  logic             card_ok;
  logic             accept;
  logic             clear_round;
  logic             load_result;
  logic [1:0]       result_next;
  logic [SUM_W-1:0] card_ext;

  // Only values 1..11 count as a card; anything else is treated as noise on the bus.
  assign card_ok  = card_valid && (card_value >= 4'd1) && (card_value <= 4'd11);
  assign accept   = card_req && card_ok;
  assign card_ext = {{(SUM_W-4){1'b0}}, card_value};

  function automatic logic is_draw(input state_t s);
    return (s == DEAL_P1) || (s == DEAL_D1) || (s == DEAL_P2) || (s == DEAL_D2) ||
           (s == PLAYER_DRAW) || (s == DEALER_DRAW);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    clear_round = 1'b0;
    load_result = 1'b0;
    result_next = result;
    unique case (state)
      IDLE, RESULT: begin
        if (start) begin
          next_state  = DEAL_P1;
          clear_round = 1'b1;
        end
      end
      DEAL_P1:     if (accept) next_state = DEAL_D1;
      DEAL_D1:     if (accept) next_state = DEAL_P2;
      DEAL_P2:     if (accept) next_state = DEAL_D2;
      DEAL_D2:     if (accept) next_state = PLAYER_TURN;
      PLAYER_TURN: begin
        if (player_sum > BUST_SUM) begin
          next_state  = RESULT;
          load_result = 1'b1;
          result_next = RES_DEALER;
        end else if (player_sum == BUST_SUM) begin
          next_state = DEALER_TURN;
        end else if (stand) begin
          next_state = DEALER_TURN;
        end else if (hit) begin
          next_state = PLAYER_DRAW;
        end
      end
      PLAYER_DRAW: if (accept) next_state = PLAYER_TURN;
      DEALER_TURN: begin
        if (dealer_sum < STAND_SUM) begin
          next_state = DEALER_DRAW;
        end else begin
          next_state  = RESULT;
          load_result = 1'b1;
          if (dealer_sum > BUST_SUM)        result_next = RES_PLAYER;
          else if (player_sum > dealer_sum) result_next = RES_PLAYER;
          else if (player_sum < dealer_sum) result_next = RES_DEALER;
          else                              result_next = RES_PUSH;
        end
      end
      DEALER_DRAW: if (accept) next_state = DEALER_TURN;
      default:     next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      card_req   <= 1'b0;
      player_sum <= '0;
      dealer_sum <= '0;
      result     <= RES_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= next_state;

      if (clear_round) begin
        player_sum <= '0;
        dealer_sum <= '0;
      end else if (accept) begin
        if (state == DEAL_P1 || state == DEAL_P2 || state == PLAYER_DRAW)
          player_sum <= player_sum + card_ext;
        else
          dealer_sum <= dealer_sum + card_ext;
      end

      if (clear_round)      result <= RES_NONE;
      else if (load_result) result <= result_next;

      // Status outputs are decoded from the next state so they line up with the state register.
      card_req <= is_draw(next_state);
      busy     <= (next_state != IDLE) && (next_state != RESULT);
      done     <= (next_state == RESULT);
    end
  end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: stimulus pushes expected round outcomes,
// a monitor pops and compares them whenever done rises.
module tb_blackjack_round_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       hit;
  logic       stand;
  logic       card_valid;
  logic [3:0] card_value;
  logic       card_req;
  logic [5:0] player_sum;
  logic [5:0] dealer_sum;
  logic [1:0] result;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    int         p;
    int         d;
    logic [1:0] r;
  } exp_t;

  exp_t sb[$];
  logic done_q = 1'b0;

  blackjack_round_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .hit        (hit),
    .stand      (stand),
    .card_valid (card_valid),
    .card_value (card_value),
    .card_req   (card_req),
    .player_sum (player_sum),
    .dealer_sum (dealer_sum),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: each rising done presents one round outcome.
  always @(negedge clock) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_player_sum"}, int'(player_sum), e.p);
        check({e.name, "_dealer_sum"}, int'(dealer_sum), e.d);
        check({e.name, "_result"}, int'(result), int'(e.r));
        check({e.name, "_busy"}, int'(busy), 0);
      end
    end
    done_q = done;
  end

  task automatic push_exp(input string name, input int p, input int d, input logic [1:0] r);
    exp_t e;
    e.name = name;
    e.p    = p;
    e.d    = d;
    e.r    = r;
    sb.push_back(e);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_hs(input logic h, input logic s);
    hit   = h;
    stand = s;
    @(negedge clock);
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  task automatic give_card(input logic [3:0] v);
    int n = 0;
    while (!card_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!card_req) begin
      check("card_req_timeout", 0, 1);
    end else begin
      card_valid = 1'b1;
      card_value = v;
      @(negedge clock);
      card_valid = 1'b0;
      card_value = 4'd0;
    end
  endtask

  task automatic deal4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    give_card(a);
    give_card(b);
    give_card(c);
    give_card(d);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!done) check({name, "_done_timeout"}, 0, 1);
    @(negedge clock);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    hit        = 1'b0;
    stand      = 1'b0;
    card_valid = 1'b0;
    card_value = 4'd0;
    repeat (2) @(negedge clock);
    check("rst_card_req", int'(card_req), 0);
    check("rst_player_sum", int'(player_sum), 0);
    check("rst_dealer_sum", int'(dealer_sum), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clock);

    // Reset while the dealer is waiting for a card aborts the round at once.
    pulse_start();
    deal4(4'd5, 4'd6, 4'd5, 4'd4);
    pulse_hs(1'b0, 1'b1);
    begin
      int n = 0;
      while (!card_req && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("abort_in_dealer_draw", int'(card_req), 1);
    card_valid = 1'b1;
    card_value = 4'd7;
    reset      = 1'b1;
    #1;
    check("abort_card_req", int'(card_req), 0);
    check("abort_player_sum", int'(player_sum), 0);
    check("abort_dealer_sum", int'(dealer_sum), 0);
    check("abort_result", int'(result), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_abort_dealer_sum", int'(dealer_sum), 0);
    check("post_abort_card_req", int'(card_req), 0);
    check("post_abort_busy", int'(busy), 0);
    card_valid = 1'b0;
    card_value = 4'd0;

    // Player stands on 18 against a dealer 17: dealer draws nothing, player wins.
    push_exp("stand18", 18, 17, 2'b01);
    pulse_start();
    deal4(4'd10, 4'd9, 4'd8, 4'd8);
    pulse_hs(1'b0, 1'b1);
    wait_done("stand18");

    // Player busts on a hit; dealer stays at 16 and no further card is requested.
    push_exp("bust", 24, 16, 2'b10);
    pulse_start();
    check("start_clears_player_sum", int'(player_sum), 0);
    check("start_clears_result", int'(result), 0);
    deal4(4'd10, 4'd7, 4'd6, 4'd9);
    pulse_hs(1'b1, 1'b0);
    give_card(4'd8);
    wait_done("bust");
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (card_req) seen++;
        @(negedge clock);
      end
      check("bust_no_card_req", seen, 0);
    end

    // Dealer draws 3 then 4 to reach 17 and stops.
    push_exp("dealer_draws", 10, 17, 2'b10);
    pulse_start();
    deal4(4'd5, 4'd6, 4'd5, 4'd4);
    pulse_hs(1'b0, 1'b1);
    give_card(4'd3);
    check("dealer_sum_13", int'(dealer_sum), 13);
    give_card(4'd4);
    wait_done("dealer_draws");

    // Illegal values are ignored, card_valid without card_req is ignored,
    // and hit+stand together resolves to stand.
    push_exp("handshake", 15, 17, 2'b10);
    pulse_start();
    card_valid = 1'b1;
    card_value = 4'd0;
    @(negedge clock);
    check("ignore0_card_req", int'(card_req), 1);
    check("ignore0_player_sum", int'(player_sum), 0);
    card_value = 4'd12;
    @(negedge clock);
    check("ignore12_card_req", int'(card_req), 1);
    check("ignore12_player_sum", int'(player_sum), 0);
    card_value = 4'd7;
    @(negedge clock);
    card_valid = 1'b0;
    card_value = 4'd0;
    check("accept7_player_sum", int'(player_sum), 7);
    give_card(4'd5);
    give_card(4'd8);
    give_card(4'd9);
    card_valid = 1'b1;
    card_value = 4'd5;
    @(negedge clock);
    card_valid = 1'b0;
    card_value = 4'd0;
    check("stray_valid_player_sum", int'(player_sum), 15);
    check("stray_valid_dealer_sum", int'(dealer_sum), 14);
    pulse_hs(1'b1, 1'b1);
    check("hit_stand_no_player_draw", int'(card_req), 0);
    give_card(4'd3);
    wait_done("handshake");

    // Player on exactly 21 advances without stand; dealer holds 17.
    push_exp("auto21", 21, 17, 2'b01);
    pulse_start();
    deal4(4'd11, 4'd10, 4'd10, 4'd7);
    wait_done("auto21");

    // Start during the player turn is ignored; dealer draws 4 to tie at 20.
    push_exp("push20", 20, 20, 2'b11);
    pulse_start();
    deal4(4'd10, 4'd10, 4'd10, 4'd6);
    pulse_start();
    check("start_while_busy_player_sum", int'(player_sum), 20);
    check("start_while_busy_busy", int'(busy), 1);
    pulse_hs(1'b0, 1'b1);
    give_card(4'd4);
    wait_done("push20");

    // Dealer busts from 16 with a 10: player wins.
    push_exp("dealer_bust", 18, 26, 2'b01);
    pulse_start();
    deal4(4'd10, 4'd10, 4'd8, 4'd6);
    pulse_hs(1'b0, 1'b1);
    give_card(4'd10);
    wait_done("dealer_bust");

    repeat (2) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
